// File: rtl/ppa_pkg.sv
// Shared types and helpers for the circular parallel-prefix round-robin arbiter.
// Helper functions operate on MAXN-wide vectors; callers size-cast to their own width.
package ppa_pkg;

  localparam int MAXN = 64;
  localparam int MAXW = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Circular rotate-left by one within the low n bits.
  function automatic logic [MAXN-1:0] rotl1(input logic [MAXN-1:0] v, input int n);
    logic [MAXN-1:0] r;
    r = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n) begin
        r[MAXW'(i)] = v[MAXW'((i + n - 1) % n)];
      end else begin
        r[MAXW'(i)] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [MAXW-1:0] onehot2bin(input logic [MAXN-1:0] v);
    logic [MAXW-1:0] b;
    b = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (v[MAXW'(i)]) begin
        b = b | MAXW'(i);
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/ppa_prefix.sv
// Combinational circular priority picker: first requester at or above the one-hot
// prio bit, wrapping, built as a Kogge-Stone style prefix of clog2(N) levels.
module ppa_prefix
  import ppa_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] prio_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  localparam int LVL = clog2(N);

  // Search reaches bit i if it started there or passed an idle bit i-1.
  logic [N-1:0] p0_s;
  assign p0_s = ~{req_i[N-2:0], req_i[N-1]};

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int S = 1 << l;
    logic [N-1:0] g_in, p_in, g_out, p_out;
    if (l == 0) begin : g_base
      assign g_in = prio_i;
      assign p_in = p0_s;
    end else begin : g_link
      assign g_in = g_lvl[l-1].g_out;
      assign p_in = g_lvl[l-1].p_out;
    end
    assign g_out = g_in | (p_in & {g_in[N-1-S:0], g_in[N-1:N-S]});
    assign p_out = p_in & {p_in[N-1-S:0], p_in[N-1:N-S]};
  end

  // The final propagate window spans every bit, so it is set only with no request.
  assign gnt_o = req_i & g_lvl[LVL-1].g_out;
  assign any_o = ~(&g_lvl[LVL-1].p_out);

endmodule

// File: rtl/ppa_rr_arb.sv
// Round-robin arbiter with per-transaction grant lock and rotating priority pointer.
// Optional per-requester weighted re-grant enabled by defining PPA_WEIGHT_EN.
module ppa_rr_arb
  import ppa_pkg::*;
#(
  parameter int N     = 8,
  parameter int WW    = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N-1:0]      i_req,
  input  logic              i_ack,
  input  logic              i_last,
`ifdef PPA_WEIGHT_EN
  input  logic [N*WW-1:0]   i_weight,
`endif
  output logic [N-1:0]      o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_valid
);

  localparam logic [N-1:0] PRIO_RST = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N-1:0]     prio_q, prio_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N-1:0]     rot_s, arb_prio_s, win_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             any_s, end_s, regrant_s;

  assign end_s      = (state_q == BUSY) & i_ack & i_last;
  assign rot_s      = N'(rotl1(MAXN'(grant_q), N));
  assign arb_prio_s = end_s ? rot_s : prio_q;
  assign win_idx_s  = IDX_W'(onehot2bin(MAXN'(win_s)));

  ppa_prefix #(.N(N)) u_prefix (
    .req_i  (i_req),
    .prio_i (arb_prio_s),
    .gnt_o  (win_s),
    .any_o  (any_s)
  );

`ifdef PPA_WEIGHT_EN
  logic [WW-1:0] credit_q, credit_d, wt_s;

  // Weight of the requester that would win now.
  always_comb begin
    wt_s = '0;
    for (int i = 0; i < N; i++) begin
      wt_s = wt_s | (i_weight[i*WW +: WW] & {WW{win_s[i]}});
    end
  end

  assign regrant_s = (credit_q != '0) & (|(i_req & grant_q));
`else
  assign regrant_s = 1'b0;
`endif

  // Next-state: start, hold, re-grant or rotate.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
`ifdef PPA_WEIGHT_EN
    credit_d = credit_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d  = BUSY;
          grant_d  = win_s;
          idx_d    = win_idx_s;
`ifdef PPA_WEIGHT_EN
          credit_d = wt_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (end_s && regrant_s) begin
`ifdef PPA_WEIGHT_EN
          credit_d = credit_q - {{(WW-1){1'b0}}, 1'b1};
`endif
        end else if (end_s) begin
          prio_d = rot_s;
          if (any_s) begin
            grant_d  = win_s;
            idx_d    = win_idx_s;
`ifdef PPA_WEIGHT_EN
            credit_d = wt_s;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, pointer and registered grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_RST;
      grant_q  <= '0;
      idx_q    <= '0;
`ifdef PPA_WEIGHT_EN
      credit_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
`ifdef PPA_WEIGHT_EN
      credit_q <= credit_d;
`endif
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_valid     = (state_q == BUSY);

endmodule

// File: tb/tb_ppa_rr_arb.sv
// Self-checking bench for ppa_rr_arb (N=8 main instance, N=5 side instance).
// Weighted re-grant sequence runs only when PPA_WEIGHT_EN is defined.
module tb_ppa_rr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  req8 = 8'h00;
  logic        ack8 = 1'b0, last8 = 1'b0;
  logic [7:0]  gnt8;
  logic [2:0]  idx8;
  logic        val8;

  logic [4:0]  req5 = 5'h00;
  logic        ack5 = 1'b0, last5 = 1'b0;
  logic [4:0]  gnt5;
  logic [2:0]  idx5;
  logic        val5;

`ifdef PPA_WEIGHT_EN
  logic [31:0] wt8 = 32'h0;
  logic [19:0] wt5 = 20'h0;
`endif

  ppa_rr_arb #(.N(8), .WW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req8), .i_ack(ack8), .i_last(last8),
`ifdef PPA_WEIGHT_EN
    .i_weight(wt8),
`endif
    .o_grant(gnt8), .o_grant_idx(idx8), .o_valid(val8)
  );

  ppa_rr_arb #(.N(5), .WW(4)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_req(req5), .i_ack(ack5), .i_last(last5),
`ifdef PPA_WEIGHT_EN
    .i_weight(wt5),
`endif
    .o_grant(gnt5), .o_grant_idx(idx5), .o_valid(val5)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic       last;
    logic [7:0] exp_gnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check8(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({name, ".grant"}, int'(gnt8), int'(e));
    chk({name, ".idx"},   int'(idx8), oh_idx(e));
    chk({name, ".valid"}, int'(val8), int'(|e));
  endtask

  task automatic step8(input string name, input logic [7:0] r, input logic a,
                       input logic l, input logic [7:0] e);
    req8 = r; ack8 = a; last8 = l;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check8(name);
  endtask

  task automatic step5(input string name, input logic [4:0] r, input logic a,
                       input logic l, input logic [4:0] e);
    req5 = r; ack5 = a; last5 = l;
    @(posedge clk); #1;
    chk({name, ".grant"}, int'(gnt5), int'(e));
    chk({name, ".idx"},   int'(idx5), oh_idx({3'b000, e}));
    chk({name, ".valid"}, int'(val5), int'(|e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req8 = 8'h00; ack8 = 1'b0; last8 = 1'b0;
    req5 = 5'h00; ack5 = 1'b0; last5 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{8'h81, 1'b0, 1'b0, 8'h01};
    vecs[1]  = '{8'h81, 1'b1, 1'b1, 8'h80};
    vecs[2]  = '{8'h81, 1'b1, 1'b1, 8'h01};
    vecs[3]  = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[4]  = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[5]  = '{8'h04, 1'b0, 1'b0, 8'h04};
    vecs[6]  = '{8'h00, 1'b1, 1'b0, 8'h04};
    vecs[7]  = '{8'hFF, 1'b1, 1'b0, 8'h04};
    vecs[8]  = '{8'h01, 1'b1, 1'b0, 8'h04};
    vecs[9]  = '{8'h80, 1'b1, 1'b0, 8'h04};
    vecs[10] = '{8'h08, 1'b1, 1'b0, 8'h04};
    vecs[11] = '{8'h0A, 1'b1, 1'b1, 8'h08};
    vecs[12] = '{8'h02, 1'b0, 1'b0, 8'h08};
    vecs[13] = '{8'h02, 1'b1, 1'b1, 8'h02};
    vecs[14] = '{8'h02, 1'b1, 1'b1, 8'h02};
    vecs[15] = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[16] = '{8'h00, 1'b0, 1'b0, 8'h00};

    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.grant", int'(gnt8), 0);
    chk("rst.idx",   int'(idx8), 0);
    chk("rst.valid", int'(val8), 0);
    chk("rst.grant5", int'(gnt5), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step8($sformatf("vec%0d", i), vecs[i].req, vecs[i].ack, vecs[i].last, vecs[i].exp_gnt);
    end

    // Asynchronous reset while owner 3 holds the grant.
    do_reset();
    step8("own3", 8'h08, 1'b0, 1'b0, 8'h08);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.grant", int'(gnt8), 0);
    chk("async_rst.valid", int'(val8), 0);
    chk("async_rst.idx",   int'(idx8), 0);
    @(negedge clk);
    rst = 1'b0;
    step8("post_rst", 8'hFF, 1'b0, 1'b0, 8'h01);

    // All requesting, one beat per transaction: strict rotation through every bit.
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] e;
      e = 8'h01 << (k % 8);
      step8($sformatf("fair%0d", k), 8'hFF, 1'b1, 1'b1, e);
    end
    step8("drain", 8'h00, 1'b1, 1'b1, 8'h00);

    // Non-power-of-two width.
    do_reset();
    step5("n5_a", 5'b10001, 1'b0, 1'b0, 5'b00001);
    step5("n5_b", 5'b10001, 1'b1, 1'b1, 5'b10000);
    step5("n5_c", 5'b10001, 1'b1, 1'b1, 5'b00001);
    step5("n5_d", 5'b10001, 1'b1, 1'b1, 5'b10000);
    for (int k = 0; k < 6; k++) begin
      logic [4:0] e;
      e = 5'b00001 << (k % 5);
      step5($sformatf("n5_rr%0d", k), 5'b11111, 1'b1, 1'b1, e);
    end
    step5("n5_idle", 5'b00000, 1'b1, 1'b1, 5'b00000);

`ifdef PPA_WEIGHT_EN
    do_reset();
    wt8 = 32'h0000_0200;
    step8("w_first", 8'h24, 1'b0, 1'b0, 8'h04);
    step8("w_re1",   8'h24, 1'b1, 1'b1, 8'h04);
    step8("w_re2",   8'h24, 1'b1, 1'b1, 8'h04);
    step8("w_rot",   8'h24, 1'b1, 1'b1, 8'h20);
    step8("w_back",  8'h24, 1'b1, 1'b1, 8'h04);
    wt8 = 32'h0;
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
